ioctl_rom_loader: RTL and testbench
===================================

// Module: ioctl_rom_loader
// PURPOSE
//   Sequences ROM/pattern-memory loading for the test suite core. Accepts ioctl download writes,
//   shares one synchronous single-port memory between the download and the core's read port,
//   holds the core in reset while loading and releases it after a clean load. Sits between the
//   sim/HPS ioctl bus and the suite core's pattern memory.
// PARAMETERS
//   AW           17     memory address width (bytes = DEPTH)
//   DEPTH        2**AW  accepted address range 0..DEPTH-1
//   INDEX        8'd0   ioctl_index value accepted for this memory
//   RD_LAT       1      memory read latency, mem_re -> mem_dout valid (1..3)
//   RST_HOLD     16     cycles core_reset stays high after load completes (>=1)
//   RUN_AT_RESET 0      1: leave reset directly into RUN; 0: wait for first download
// PORTS
//   clk_sys        in   1   system clock, all logic rising-edge
//   reset_n        in   1   asynchronous, active-low reset
//   ioctl_download in   1   download window active
//   ioctl_index    in   8   download target index
//   ioctl_wr       in   1   write strobe, one byte per high cycle
//   ioctl_addr     in   25  byte address
//   ioctl_dout     in   8   write data
//   ioctl_wait     out  1   stall: ioctl must hold ioctl_wr/addr/dout while high
//   rd_req         in   1   core read request, level, held until rd_ack
//   rd_addr        in   AW  core read address, stable while rd_req
//   rd_ack         out  1   one-cycle pulse, rd_data valid
//   rd_data        out  8   read data
//   mem_addr       out  AW  memory address
//   mem_din        out  8   memory write data
//   mem_we         out  1   memory write enable
//   mem_re         out  1   memory read enable
//   mem_dout       in   8   memory read data
//   core_reset     out  1   active-high reset to suite core
//   load_size      out  AW+1 highest accepted address+1 of last download
//   load_err       out  1   sticky: out-of-range write seen this download
// BEHAVIOUR
//   Reset (async): ioctl_wait=0, mem_we=0, mem_re=0, rd_ack=0, rd_data=0, load_size=0,
//     load_err=0, core_reset=1, hold register empty, state IDLE (RUN_AT_RESET=1: RUN, core_reset=0).
//   States: IDLE -> LOADING on ioctl_download=1 & ioctl_index==INDEX;
//     RUN -> LOADING same condition; LOADING -> FLUSH on ioctl_download=0;
//     FLUSH -> RELEASE when hold empty and no read in flight; RELEASE counts RST_HOLD cycles -> RUN.
//   core_reset: 1 in IDLE/LOADING/FLUSH/RELEASE, registered; goes 0 on entry to RUN.
//   Entering LOADING clears load_size and load_err the same edge.
//   Download write: ioctl_wr=1 & LOADING & !ioctl_wait -> capture {addr,data} into 1-entry hold.
//     ioctl_wait = hold valid (registered). Hold drains next cycle: mem_we=1, mem_addr/mem_din.
//     Net: write accepted at cycle N, mem_we at N+1, ioctl_wait high at N+1, next accept N+2.
//   Out-of-range (ioctl_addr>=DEPTH): not captured, no mem_we, no wait, load_err<=1.
//   load_size <= max(load_size, addr+1) for each accepted write.
//   ioctl_wr with wrong index or outside LOADING: ignored, no wait, no side effect.
//   Reads: only in RUN. mem_re=1 for one cycle when rd_req=1, no read in flight, hold empty;
//     rd_ack pulses RD_LAT cycles later with rd_data=mem_dout; one read in flight max.
//     Next mem_re no earlier than cycle after rd_ack (rd_req still high = new request).
//   Write has priority over read on the mem port in every cycle; mem_we and mem_re never both 1.
//   Download start while a read is in flight: read completes, rd_ack still pulses; no new reads.
//   ioctl_download falling while hold full: write still drains in FLUSH before RELEASE.
//   reset_n low mid-download: all state cleared immediately; ioctl_wait=0; partial data in memory
//     is not erased; loading restarts only on a new download window.
// TESTING
//   Reset: reset_n=0 -> ioctl_wait=0, mem_we=0, rd_ack=0, core_reset=1, load_size=0 in IDLE.
//   Download idx 0, bytes 0x11,0x22,0x33,0x44 @0..3 -> 4 mem_we pulses, each 1 cycle after accept,
//     ioctl_wait 1 cycle each, load_size=4, load_err=0; core_reset=0 RST_HOLD+1 cycles after FLUSH empty.
//   Write @addr=DEPTH during download -> no mem_we, load_err=1; cleared at next download start.
//   ioctl_index=1 download -> no mem_we, no ioctl_wait, state and core_reset unchanged.
//   RUN, rd_req @addr 2 -> mem_re 1 cycle, rd_ack after RD_LAT with rd_data=0x33; back-to-back reqs
//     gap = RD_LAT+1 cycles.
//   reset_n pulse mid-download with hold full -> ioctl_wait=0, mem_we=0 next edge, state IDLE.

Source files
------------

// File: rtl/ioctl_rom_loader_if.sv
// ioctl download bus between the sim/HPS side (master) and the ROM loader (slave).
interface ioctl_rom_loader_if;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wait;

    modport master (
        output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
        input  ioctl_wait
    );

    modport slave (
        input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
        output ioctl_wait
    );
endinterface

// File: rtl/ioctl_rom_loader.sv
// ROM/pattern-memory loader: takes ioctl download bytes through a one-entry hold
// register, shares a single-port synchronous memory with the core read port
// (writes win), and keeps the core in reset until a load has fully drained.
module ioctl_rom_loader #(
    parameter int unsigned AW           = 17,
    parameter int unsigned DEPTH        = 2**AW,
    parameter logic [7:0]  INDEX        = 8'd0,
    parameter int unsigned RD_LAT       = 1,
    parameter int unsigned RST_HOLD     = 16,
    parameter bit          RUN_AT_RESET = 1'b0
) (
    input  logic                  clk_sys,
    input  logic                  reset_n,
    ioctl_rom_loader_if.slave     ioctl,
    input  logic                  rd_req,
    input  logic [AW-1:0]         rd_addr,
    output logic                  rd_ack,
    output logic [7:0]            rd_data,
    output logic [AW-1:0]         mem_addr,
    output logic [7:0]            mem_din,
    output logic                  mem_we,
    output logic                  mem_re,
    input  logic [7:0]            mem_dout,
    output logic                  core_reset,
    output logic [AW:0]           load_size,
    output logic                  load_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOADING,
        S_FLUSH,
        S_RELEASE,
        S_RUN
    } state_e;

    localparam state_e RESET_STATE = RUN_AT_RESET ? S_RUN : S_IDLE;
    localparam int     CW          = $clog2(RST_HOLD + 1);

    state_e              state_q, state_d;
    logic [CW-1:0]       hold_cnt_q;
    logic                hold_valid_q;
    logic [AW-1:0]       hold_addr_q;
    logic [7:0]          hold_data_q;
    logic [RD_LAT-1:0]   rd_pipe_q;
    logic [7:0]          rd_data_q;
    logic                core_reset_q, core_reset_d;
    logic [AW:0]         load_size_q;
    logic                load_err_q;
    logic                load_clear;

    logic                dl_match;
    logic                wr_seen;
    logic                addr_ok;
    logic                wr_accept;
    logic                wr_oor;
    logic                rd_busy;
    logic                rd_start;
    logic [AW:0]         wr_size;

    assign dl_match  = ioctl.ioctl_download && (ioctl.ioctl_index == INDEX);
    // A write is only looked at while loading this index and the hold has room.
    assign wr_seen   = ioctl.ioctl_wr && (state_q == S_LOADING)
                       && (ioctl.ioctl_index == INDEX) && !hold_valid_q;
    assign addr_ok   = ({1'b0, ioctl.ioctl_addr} < 26'(DEPTH));
    assign wr_accept = wr_seen && addr_ok;
    assign wr_oor    = wr_seen && !addr_ok;
    assign wr_size   = {1'b0, ioctl.ioctl_addr[AW-1:0]} + (AW+1)'(1);
    // The ack stage counts as in flight so the next read starts the cycle after rd_ack.
    assign rd_busy   = |rd_pipe_q;
    assign rd_start  = (state_q == S_RUN) && rd_req && !rd_busy && !hold_valid_q;

    // State register.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
        if (!reset_n) begin
            state_q <= RESET_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode of the load / release / run sequence.
    always_comb begin
        // NOTE: default first so a missing branch holds the state instead of inferring a latch.
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_RUN: if (dl_match)                    state_d = S_LOADING;
            S_LOADING:     if (!ioctl.ioctl_download)       state_d = S_FLUSH;
            S_FLUSH:       if (!hold_valid_q && !rd_busy)   state_d = S_RELEASE;
            S_RELEASE:     if (hold_cnt_q == CW'(RST_HOLD - 1)) state_d = S_RUN;
            default:                                        state_d = S_IDLE;
        endcase
    end

    // Output decode: memory port mux (hold write beats read), core reset and load-stat clear.
    always_comb begin
        mem_we       = hold_valid_q;
        mem_re       = rd_start;
        mem_addr     = hold_valid_q ? hold_addr_q : rd_addr;
        mem_din      = hold_data_q;
        core_reset_d = (state_d != S_RUN);
        load_clear   = (state_d == S_LOADING) && (state_q != S_LOADING);
    end

    // Release counter runs only while in RELEASE.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            hold_cnt_q <= '0;
        end else if (state_q != S_RELEASE) begin
            hold_cnt_q <= '0;
        end else begin
            hold_cnt_q <= hold_cnt_q + CW'(1);
        end
    end

    // One-entry write hold: filled on accept, always drained on the following cycle.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        // NOTE: the hold payload is reset too; the external memory contents are never cleared.
        if (!reset_n) begin
            hold_valid_q <= 1'b0;
            hold_addr_q  <= '0;
            hold_data_q  <= '0;
        end else begin
            hold_valid_q <= wr_accept;
            if (wr_accept) begin
                hold_addr_q <= ioctl.ioctl_addr[AW-1:0];
                hold_data_q <= ioctl.ioctl_dout;
            end
        end
    end

    // Load statistics: cleared on entry to LOADING, then track size and out-of-range hits.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            load_size_q <= '0;
            load_err_q  <= 1'b0;
        end else if (load_clear) begin
            load_size_q <= '0;
            load_err_q  <= 1'b0;
        end else begin
            if (wr_accept && (wr_size > load_size_q)) begin
                load_size_q <= wr_size;
            end
            if (wr_oor) begin
                load_err_q <= 1'b1;
            end
        end
    end

    // Read latency pipeline and last-read data register.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            rd_pipe_q <= '0;
            rd_data_q <= '0;
        end else begin
            rd_pipe_q <= (rd_pipe_q << 1) | RD_LAT'(rd_start);
            if (rd_ack) begin
                rd_data_q <= mem_dout;
            end
        end
    end

    // Registered core reset, low only while running.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            core_reset_q <= !RUN_AT_RESET;
        end else begin
            core_reset_q <= core_reset_d;
        end
    end

    assign ioctl.ioctl_wait = hold_valid_q;
    assign rd_ack           = rd_pipe_q[RD_LAT-1];
    // Memory data passes straight through in the ack cycle and is held afterwards.
    assign rd_data          = rd_ack ? mem_dout : rd_data_q;
    assign core_reset       = core_reset_q;
    assign load_size        = load_size_q;
    assign load_err         = load_err_q;

endmodule

// File: tb/tb_ioctl_rom_loader.sv
// Bench for ioctl_rom_loader: drives the ioctl bus and the core read port, models the
// external memory, and checks memory writes and read data through a scoreboard.
module tb_ioctl_rom_loader;

    localparam int          AW       = 10;
    localparam int          DEPTH    = 1 << AW;
    localparam int          RD_LAT   = 2;
    localparam int          RST_HOLD = 5;
    localparam logic [7:0]  INDEX    = 8'd0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    data;
        int            cyc;
    } wr_exp_t;

    logic            clk_sys = 1'b0;
    logic            reset_n;
    logic            rd_req;
    logic [AW-1:0]   rd_addr;
    logic            rd_ack;
    logic [7:0]      rd_data;
    logic [AW-1:0]   mem_addr;
    logic [7:0]      mem_din;
    logic            mem_we;
    logic            mem_re;
    logic [7:0]      mem_dout;
    logic            core_reset;
    logic [AW:0]     load_size;
    logic            load_err;

    ioctl_rom_loader_if ioc();

    ioctl_rom_loader #(
        .AW(AW), .DEPTH(DEPTH), .INDEX(INDEX), .RD_LAT(RD_LAT),
        .RST_HOLD(RST_HOLD), .RUN_AT_RESET(1'b0)
    ) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .ioctl(ioc),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_re(mem_re),
        .mem_dout(mem_dout), .core_reset(core_reset), .load_size(load_size),
        .load_err(load_err)
    );

    always #5 clk_sys = ~clk_sys;

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    // External synchronous memory with RD_LAT cycles of read latency.
    logic [7:0] hmem  [DEPTH];
    logic [7:0] hpipe [RD_LAT];
    always @(posedge clk_sys) begin
        if (mem_we) hmem[mem_addr] <= mem_din;
        if (mem_re) hpipe[0] <= hmem[mem_addr];
        for (int i = 1; i < RD_LAT; i++) hpipe[i] <= hpipe[i-1];
    end
    assign mem_dout = hpipe[RD_LAT-1];

    // Reference model state.
    logic [7:0] ref_mem [int];
    int         written[$];
    int         rd_list[$];
    int         exp_size;
    bit         exp_err;
    int         prev_k;
    bit         prev_stall;

    wr_exp_t    we_q[$];
    logic [7:0] rd_q[$];

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input bit ok, input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT writes memory or acks a read.
    wr_exp_t    mon_e;
    logic [7:0] mon_d;
    always @(negedge clk_sys) begin
        if (reset_n) begin
            if (mem_we || mem_re) begin
                check(!(mem_we && mem_re), "we_re_overlap", 32'(mem_re), 32'(0));
                check(ioc.ioctl_wait == mem_we, "wait_vs_we", 32'(ioc.ioctl_wait), 32'(mem_we));
            end
            if (mem_we) begin
                if (we_q.size() == 0) begin
                    check(1'b0, "unexpected_mem_we", 32'(mem_addr), 32'(0));
                end else begin
                    mon_e = we_q.pop_front();
                    check(mem_addr == mon_e.addr, "we_addr", 32'(mem_addr), 32'(mon_e.addr));
                    check(mem_din == mon_e.data, "we_data", 32'(mem_din), 32'(mon_e.data));
                    check(cyc == mon_e.cyc, "we_timing", cyc, mon_e.cyc);
                end
            end
            if (rd_ack) begin
                if (rd_q.size() == 0) begin
                    check(1'b0, "unexpected_rd_ack", 32'(rd_data), 32'(0));
                end else begin
                    mon_d = rd_q.pop_front();
                    check(rd_data == mon_d, "rd_data", 32'(rd_data), 32'(mon_d));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // One ioctl byte write, honouring ioctl_wait; 'loading' says the DUT should take it.
    task automatic ioctl_write(input logic [24:0] a, input logic [7:0] d,
                               input bit loading, input bit b2b);
        bit      w;
        bit      acc;
        bit      in_rng;
        int      k;
        wr_exp_t e;
        in_rng = (a < 25'(DEPTH));
        ioc.ioctl_wr   = 1'b1;
        ioc.ioctl_addr = a;
        ioc.ioctl_dout = d;
        acc = 1'b0;
        for (int t = 0; t < 20 && !acc; t++) begin
            @(negedge clk_sys);
            w = ioc.ioctl_wait;
            @(posedge clk_sys);
            #1;
            acc = !w;
        end
        ioc.ioctl_wr = 1'b0;
        k = cyc;
        if (!acc) check(1'b0, "write_accept_timeout", 32'(a), 32'(0));
        if (b2b) check(k - prev_k == (prev_stall ? 2 : 1), "write_spacing",
                       k - prev_k, prev_stall ? 2 : 1);
        prev_k     = k;
        prev_stall = loading && in_rng;
        if (loading) begin
            if (in_rng) begin
                e.addr = a[AW-1:0];
                e.data = d;
                e.cyc  = k;
                we_q.push_back(e);
                ref_mem[int'(a)] = d;
                written.push_back(int'(a));
                if (int'(a) + 1 > exp_size) exp_size = int'(a) + 1;
            end else begin
                exp_err = 1'b1;
            end
        end
    endtask

    task automatic start_download(input logic [7:0] idx);
        ioc.ioctl_index    = idx;
        ioc.ioctl_download = 1'b1;
        if (idx == INDEX) begin
            exp_size = 0;
            exp_err  = 1'b0;
        end
        tick();
    endtask

    // Drop the window and time the core reset release, then check load statistics.
    task automatic end_download();
        int d;
        bit dropped;
        ioc.ioctl_download = 1'b0;
        d = cyc;
        dropped = 1'b0;
        for (int t = 0; t < 100 && !dropped; t++) begin
            @(negedge clk_sys);
            dropped = !core_reset;
        end
        check(dropped && (cyc - d == RST_HOLD + 2), "core_reset_release", cyc - d, RST_HOLD + 2);
        tick();
        check(int'(load_size) == exp_size, "load_size", 32'(load_size), exp_size);
        check(load_err == exp_err, "load_err", 32'(load_err), 32'(exp_err));
    endtask

    // Back-to-back reads of rd_list, checking issue gap and ack latency.
    task automatic do_reads();
        int c;
        int prev_c;
        bit seen;
        prev_c = 0;
        for (int i = 0; i < rd_list.size(); i++) begin
            rd_addr = AW'(rd_list[i]);
            rd_req  = 1'b1;
            rd_q.push_back(ref_mem[rd_list[i]]);
            seen = 1'b0;
            for (int t = 0; t < 50 && !seen; t++) begin
                @(negedge clk_sys);
                seen = mem_re;
            end
            c = cyc;
            check(seen, "read_issue", 32'(seen), 32'(1));
            check(mem_addr == rd_addr, "read_addr", 32'(mem_addr), 32'(rd_addr));
            if (i > 0) check(c - prev_c == RD_LAT + 1, "read_gap", c - prev_c, RD_LAT + 1);
            prev_c = c;
            seen = 1'b0;
            for (int t = 0; t < 50 && !seen; t++) begin
                @(negedge clk_sys);
                seen = rd_ack;
            end
            check(seen && (cyc - c == RD_LAT), "read_latency", cyc - c, RD_LAT);
            tick();
        end
        rd_req = 1'b0;
    endtask

    // Counts mem_re pulses over n cycles with rd_req held high.
    task automatic count_reads(input int n, output int cnt);
        cnt = 0;
        for (int t = 0; t < n; t++) begin
            @(negedge clk_sys);
            if (mem_re) cnt++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         c;
        int         cnt;
        int         g;
        bit         seen;
        logic [24:0] a;

        reset_n = 1'b0;
        rd_req  = 1'b0;
        rd_addr = '0;
        ioc.ioctl_download = 1'b0;
        ioc.ioctl_index    = 8'd0;
        ioc.ioctl_wr       = 1'b0;
        ioc.ioctl_addr     = '0;
        ioc.ioctl_dout     = '0;
        exp_size   = 0;
        exp_err    = 1'b0;
        prev_k     = 0;
        prev_stall = 1'b0;

        // Reset values.
        repeat (2) @(posedge clk_sys);
        @(negedge clk_sys);
        check(ioc.ioctl_wait == 1'b0, "rst_wait", 32'(ioc.ioctl_wait), 32'(0));
        check(mem_we == 1'b0, "rst_mem_we", 32'(mem_we), 32'(0));
        check(mem_re == 1'b0, "rst_mem_re", 32'(mem_re), 32'(0));
        check(rd_ack == 1'b0, "rst_rd_ack", 32'(rd_ack), 32'(0));
        check(rd_data == 8'h00, "rst_rd_data", 32'(rd_data), 32'(0));
        check(core_reset == 1'b1, "rst_core_reset", 32'(core_reset), 32'(1));
        check(load_size == '0, "rst_load_size", 32'(load_size), 32'(0));
        check(load_err == 1'b0, "rst_load_err", 32'(load_err), 32'(0));
        @(posedge clk_sys);
        #1;
        reset_n = 1'b1;
        tick();

        // IDLE: reads are not served.
        rd_addr = '0;
        rd_req  = 1'b1;
        count_reads(4, cnt);
        check(cnt == 0, "idle_no_read", cnt, 0);
        rd_req = 1'b0;
        tick();

        // Wrong index in IDLE: ignored entirely.
        start_download(8'd1);
        ioctl_write(25'd5, 8'hAA, 1'b0, 1'b0);
        ioctl_write(25'd6, 8'hBB, 1'b0, 1'b1);
        ioc.ioctl_download = 1'b0;
        repeat (3) tick();
        check(core_reset == 1'b1, "wrong_idx_idle_core_reset", 32'(core_reset), 32'(1));
        check(load_size == '0, "wrong_idx_idle_size", 32'(load_size), 32'(0));

        // Directed download of four bytes.
        start_download(INDEX);
        ioctl_write(25'd0, 8'h11, 1'b1, 1'b0);
        ioctl_write(25'd1, 8'h22, 1'b1, 1'b1);
        ioctl_write(25'd2, 8'h33, 1'b1, 1'b1);
        ioctl_write(25'd3, 8'h44, 1'b1, 1'b1);
        end_download();
        check(int'(load_size) == 4, "directed_size", 32'(load_size), 32'(4));

        // Single read then back-to-back reads.
        rd_list = '{2};
        do_reads();
        rd_list = '{0, 1, 2, 3};
        do_reads();

        // Wrong index while running: core stays out of reset.
        start_download(8'd1);
        ioctl_write(25'd7, 8'hCC, 1'b0, 1'b0);
        ioctl_write(25'd8, 8'hDD, 1'b0, 1'b1);
        repeat (3) tick();
        check(core_reset == 1'b0, "wrong_idx_run_core_reset", 32'(core_reset), 32'(0));
        ioc.ioctl_download = 1'b0;
        repeat (3) tick();
        check(core_reset == 1'b0, "wrong_idx_run_after", 32'(core_reset), 32'(0));
        check(int'(load_size) == exp_size, "wrong_idx_run_size", 32'(load_size), exp_size);

        // Randomized download with out-of-range writes mixed in.
        start_download(INDEX);
        ioctl_write(25'(DEPTH), 8'h99, 1'b1, 1'b0);
        ioctl_write(25'd16, 8'($urandom), 1'b1, 1'b1);
        for (int i = 0; i < 24; i++) begin
            g = $urandom_range(0, 2);
            repeat (g) tick();
            if ($urandom_range(0, 9) == 0) a = 25'(DEPTH + $urandom_range(0, 500));
            else                           a = 25'($urandom_range(16, DEPTH - 1));
            ioctl_write(a, 8'($urandom), 1'b1, g == 0);
        end
        end_download();
        check(load_err == 1'b1, "oor_load_err", 32'(load_err), 32'(1));

        // Download starts while a read is in flight: the read still completes.
        rd_addr = AW'(2);
        rd_req  = 1'b1;
        rd_q.push_back(ref_mem[2]);
        seen = 1'b0;
        for (int t = 0; t < 50 && !seen; t++) begin
            @(negedge clk_sys);
            seen = mem_re;
        end
        c = cyc;
        ioc.ioctl_index    = INDEX;
        ioc.ioctl_download = 1'b1;
        exp_size = 0;
        exp_err  = 1'b0;
        seen = 1'b0;
        for (int t = 0; t < 50 && !seen; t++) begin
            @(negedge clk_sys);
            seen = rd_ack;
        end
        check(seen && (cyc - c == RD_LAT), "inflight_latency", cyc - c, RD_LAT);
        count_reads(6, cnt);
        check(cnt == 0, "no_read_in_loading", cnt, 0);
        rd_req = 1'b0;
        check(core_reset == 1'b1, "loading_core_reset", 32'(core_reset), 32'(1));
        check(load_err == 1'b0, "load_err_cleared", 32'(load_err), 32'(0));
        check(load_size == '0, "load_size_cleared", 32'(load_size), 32'(0));
        tick();
        ioctl_write(25'd40, 8'h5C, 1'b1, 1'b0);
        ioctl_write(25'd41, 8'hC5, 1'b1, 1'b1);
        end_download();

        // Random reads of written locations.
        rd_list.delete();
        for (int i = 0; i < 20; i++) rd_list.push_back(written[$urandom_range(0, written.size() - 1)]);
        do_reads();

        // Reset in the middle of a download with the hold full.
        start_download(INDEX);
        ioc.ioctl_wr   = 1'b1;
        ioc.ioctl_addr = 25'd200;
        ioc.ioctl_dout = 8'h5A;
        tick();
        ioc.ioctl_wr = 1'b0;
        check(ioc.ioctl_wait == 1'b1, "hold_full_before_reset", 32'(ioc.ioctl_wait), 32'(1));
        reset_n = 1'b0;
        ioc.ioctl_download = 1'b0;
        #1;
        check(ioc.ioctl_wait == 1'b0, "reset_async_wait", 32'(ioc.ioctl_wait), 32'(0));
        @(negedge clk_sys);
        check(mem_we == 1'b0, "reset_mem_we", 32'(mem_we), 32'(0));
        check(core_reset == 1'b1, "reset_core_reset", 32'(core_reset), 32'(1));
        check(load_size == '0, "reset_load_size", 32'(load_size), 32'(0));
        tick();
        reset_n = 1'b1;
        repeat (2) tick();
        rd_addr = AW'(2);
        rd_req  = 1'b1;
        count_reads(4, cnt);
        check(cnt == 0, "post_reset_idle_no_read", cnt, 0);
        rd_req = 1'b0;
        tick();
        ioctl_write(25'd9, 8'hEE, 1'b0, 1'b0);
        ioctl_write(25'd10, 8'hEF, 1'b0, 1'b1);
        check(core_reset == 1'b1, "post_reset_core_reset", 32'(core_reset), 32'(1));

        // Fresh download, then read back old and new data.
        start_download(INDEX);
        ioctl_write(25'd300, 8'($urandom), 1'b1, 1'b0);
        ioctl_write(25'd301, 8'($urandom), 1'b1, 1'b1);
        end_download();
        rd_list = '{2, 300, 301, 3};
        do_reads();

        repeat (4) tick();
        check(we_q.size() == 0, "pending_writes", we_q.size(), 0);
        check(rd_q.size() == 0, "pending_reads", rd_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
